// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Imported by serial_adder; holds the FSM state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_CNT_W = 1;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? MIN_CNT_W : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full-adder cell; the per-bit slice of the serial adder.
// Purely combinational.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b mode).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_nxt;
    logic [WIDTH-1:0] w_ld_b;
    logic             w_ld_c;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1; cout then reads as "no borrow".
    assign w_ld_b = sub ? ~b : b;
    assign w_ld_c = sub ? 1'b1 : cin;
`else
    assign w_ld_b = b;
    assign w_ld_c = cin;
`endif

    fulladder u_fa (
        .a    (r_sha[0]),
        .b    (r_shb[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    assign w_res_nxt = {w_s, r_res};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sha   <= '0;
            r_shb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sha   <= a;
                        r_shb   <= w_ld_b;
                        r_carry <= w_ld_c;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_c;
                    r_res   <= w_res_nxt[WIDTH-1:1];
                    r_sha   <= r_sha >> 1;
                    r_shb   <= r_shb >> 1;
                    if (r_cnt == LAST) begin
                        // Counter parks at zero so it never wraps.
                        r_cnt   <= '0;
                        r_sum   <= w_res_nxt;
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random ops
// against an arithmetic reference; covers SERIAL_ADDER_SUB_EN when defined.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           vecs = 0;
    int           errs = 0;
    logic [W-1:0] last_sum;
    logic         last_cout;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {cout,sum} from plain integer arithmetic.
    function automatic logic [W:0] ref_model(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic c,
                                             input logic s);
        int r;
        if (s) r = int'(x) - int'(y) + (1 << W);
        else   r = int'(x) + int'(y) + int'(c);
        r = r % (1 << (W + 1));
        return (W+1)'(r);
    endfunction

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts, input bit inject);
        logic [W:0] e;
        int cyc;
        e = ref_model(ta, tb, tc, ts);
        @(negedge clk);
        a = ta;
        b = tb;
        cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        cyc = 0;
        while (!done && cyc < W + 4) begin
            check("busy_run", busy, 1);
            check("sum_hold", sum, last_sum);
            check("cout_hold", cout, last_cout);
            if (inject && cyc == 2) begin
                start = 1'b1;
                a = 8'h01;
                b = 8'h01;
                cin = 1'b0;
            end
            if (inject && cyc == 4) start = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, W);
        check("sum", sum, e[W-1:0]);
        check("cout", cout, e[W]);
        check("busy_done", busy, 1);
        last_sum = e[W-1:0];
        last_cout = e[W];
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        if (inject) begin
            repeat (W + 3) begin
                @(posedge clk);
                #1;
                check("no_second_done", done, 0);
                check("sum_kept", sum, last_sum);
            end
        end
    endtask

    initial begin
        int t;
        int n;
        int prev;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        last_sum = '0;
        last_cout = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst = 1'b0;

        do_op(8'h3C, 8'h05, 1'b0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op(8'h3C, 8'h05, 1'b0, 1'b0, 1'b1);
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a run.
        @(negedge clk);
        a = 8'h77;
        b = 8'h11;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        last_sum = '0;
        last_cout = 1'b0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            check("mid_rst_no_done", done, 0);
        end
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);

        // Start held high: back-to-back ops.
        @(negedge clk);
        a = 8'h80;
        b = 8'h80;
        cin = 1'b0;
        start = 1'b1;
        t = 0;
        n = 0;
        prev = -1;
        while (n < 4 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
            if (done) begin
                check("held_sum", sum, 8'h00);
                check("held_cout", cout, 1);
                if (prev >= 0) check("held_period", t - prev, W + 2);
                prev = t;
                n++;
            end
        end
        check("held_pulses", n, 4);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        last_sum = 8'h00;
        last_cout = 1'b1;

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        do_op(8'h07, 8'h05, 1'b1, 1'b1, 1'b0);
`endif

        repeat (20) begin
`ifdef SERIAL_ADDER_SUB_EN
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
`else
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  1'b0, 1'b0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
